// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port arbiter and the RAM.
// master = requesters plus RAM model, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 64
);
  logic                 req_f;
  logic [ADDR_BITS-1:0] addr_f;
  logic                 req_d;
  logic                 we_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [DATA_BITS-1:0] wdata_d;
  logic                 ack_f;
  logic                 ack_d;
  logic [DATA_BITS-1:0] rdata;
  logic                 busy;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_rdata,
    input  ack_f, ack_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_rdata,
    output ack_f, ack_d, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch and data
// access; data wins ties except when its burst streak would starve fetch.
module mem_port_arbiter #(
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = 64,
  parameter int MEM_LAT     = 1,
  parameter int MAX_D_BURST = 4
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_LAST  = 3'(MEM_LAT - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [3:0]           streak_r;
  logic [2:0]           wait_cnt_r;
  logic                 id_d_r;
  logic                 we_r;
  logic                 grant_d_s;
  logic                 grant_f_s;
  logic                 wait_done_s;

  logic                 ack_f_r, ack_d_r, busy_r, mem_en_r, mem_we_r;
  logic [ADDR_BITS-1:0] mem_addr_r;
  logic [DATA_BITS-1:0] mem_wdata_r, rdata_r;

  logic                 ack_f_nxt_s, ack_d_nxt_s, busy_nxt_s, mem_en_nxt_s, mem_we_nxt_s;
  logic [ADDR_BITS-1:0] mem_addr_nxt_s;
  logic [DATA_BITS-1:0] mem_wdata_nxt_s, rdata_nxt_s;

  assign wait_done_s = (wait_cnt_r == LAT_LAST);

  // Arbitration: data first unless the streak has reached its limit while fetch waits
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    if (state_r == IDLE) begin
      if (bus.req_d && !(bus.req_f && (streak_r == BURST_MAX))) begin
        grant_d_s = 1'b1;
      end else if (bus.req_f) begin
        grant_f_s = 1'b1;
      end else begin
        grant_f_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s || grant_f_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_next_s = ACK;
        end else begin
          state_next_s = WAIT;
        end
      end
      WAIT: begin
        if (wait_done_s) begin
          state_next_s = ACK;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output logic, computed one cycle ahead so every output leaves a flop
  always_comb begin
    mem_en_nxt_s    = (state_next_s == ISSUE);
    busy_nxt_s      = (state_next_s != IDLE);
    ack_f_nxt_s     = (state_next_s == ACK) && !id_d_r;
    ack_d_nxt_s     = (state_next_s == ACK) && id_d_r;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = '0;
    mem_wdata_nxt_s = '0;
    rdata_nxt_s     = rdata_r;
    // ISSUE is only ever entered from IDLE, so the grant mux is the source here
    if (state_next_s == ISSUE) begin
      mem_we_nxt_s    = grant_d_s && bus.we_d;
      mem_addr_nxt_s  = grant_d_s ? bus.addr_d : bus.addr_f;
      mem_wdata_nxt_s = grant_d_s ? bus.wdata_d : '0;
    end else begin
      mem_we_nxt_s    = 1'b0;
    end
    if ((state_r == WAIT) && wait_done_s) begin
      rdata_nxt_s = bus.mem_rdata;
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_f_r     <= 1'b0;
      ack_d_r     <= 1'b0;
      busy_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rdata_r     <= '0;
    end else begin
      ack_f_r     <= ack_f_nxt_s;
      ack_d_r     <= ack_d_nxt_s;
      busy_r      <= busy_nxt_s;
      mem_en_r    <= mem_en_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      rdata_r     <= rdata_nxt_s;
    end
  end

  // Grant bookkeeping: requester id, op type, burst streak and wait counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak_r   <= 4'd0;
      wait_cnt_r <= 3'd0;
      id_d_r     <= 1'b0;
      we_r       <= 1'b0;
    end else begin
      if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + 3'd1;
      end else begin
        wait_cnt_r <= 3'd0;
      end
      if (grant_d_s) begin
        id_d_r <= 1'b1;
        we_r   <= bus.we_d;
        if (bus.req_f && (streak_r != BURST_MAX)) begin
          streak_r <= streak_r + 4'd1;
        end else if (!bus.req_f) begin
          streak_r <= 4'd0;
        end
      end else if (grant_f_s) begin
        id_d_r   <= 1'b0;
        we_r     <= 1'b0;
        streak_r <= 4'd0;
      end
    end
  end

  assign bus.ack_f     = ack_f_r;
  assign bus.ack_d     = ack_d_r;
  assign bus.busy      = busy_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rdata     = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with its own small RAM model.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic rst1  = 1'b1;
  logic rst3  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(64)) b1 ();
  mem_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(64)) b3 ();

  mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(64), .MEM_LAT(1), .MAX_D_BURST(4)) dut1 (
    .clock(clock), .reset(rst1), .bus(b1.slave)
  );
  mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(64), .MEM_LAT(3), .MAX_D_BURST(4)) dut3 (
    .clock(clock), .reset(rst3), .bus(b3.slave)
  );

  logic [63:0] ram1 [0:255];
  logic [63:0] ram3 [0:255];
  logic [63:0] rd1;
  logic [63:0] p3 [0:2];

  // RAM models: read data is present only in the cycle(s) dictated by the latency
  always @(posedge clock) begin
    if (b1.mem_en && b1.mem_we) ram1[b1.mem_addr[7:0]] <= b1.mem_wdata;
    rd1 <= (b1.mem_en && !b1.mem_we) ? ram1[b1.mem_addr[7:0]] : 64'd0;
    if (b3.mem_en && b3.mem_we) ram3[b3.mem_addr[7:0]] <= b3.mem_wdata;
    p3[0] <= (b3.mem_en && !b3.mem_we) ? ram3[b3.mem_addr[7:0]] : 64'd0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = p3[2];

  function automatic logic [148:0] outs1();
    return {b1.ack_f, b1.ack_d, b1.busy, b1.mem_en, b1.mem_we,
            b1.mem_addr, b1.mem_wdata, b1.rdata};
  endfunction

  function automatic logic [148:0] outs3();
    return {b3.ack_f, b3.ack_d, b3.busy, b3.mem_en, b3.mem_we,
            b3.mem_addr, b3.mem_wdata, b3.rdata};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    checks++;
    if (outs1() !== 149'd0) begin
      failures++;
      $display("FAIL reset_outputs_lat1 got=%h expected=0", outs1());
    end
    checks++;
    if (outs3() !== 149'd0) begin
      failures++;
      $display("FAIL reset_outputs_lat3 got=%h expected=0", outs3());
    end
  endtask

  task automatic test_idle();
    int active = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (b1.busy || b1.mem_en || b1.ack_f || b1.ack_d) active++;
    end
    checks++;
    if (active !== 0) begin
      failures++;
      $display("FAIL idle_quiet active_cycles=%0d expected=0", active);
    end
  endtask

  task automatic test_fetch();
    b1.addr_f = 16'h0010;
    b1.req_f  = 1'b1;
    step();
    checks++;
    if ({b1.mem_en, b1.mem_we, b1.mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      failures++;
      $display("FAIL fetch_issue en/we/addr=%b/%b/%h expected=1/0/0010", b1.mem_en, b1.mem_we, b1.mem_addr);
    end
    checks++;
    if (b1.busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_busy got=%b expected=1", b1.busy);
    end
    step();
    checks++;
    if ({b1.mem_en, b1.ack_f} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_wait en/ack_f=%b/%b expected=0/0", b1.mem_en, b1.ack_f);
    end
    step();
    checks++;
    if ({b1.ack_f, b1.ack_d} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_ack ack_f/ack_d=%b/%b expected=1/0", b1.ack_f, b1.ack_d);
    end
    checks++;
    if (b1.rdata !== 64'h00000000DEADBEEF) begin
      failures++;
      $display("FAIL fetch_rdata got=%h expected=00000000deadbeef", b1.rdata);
    end
    b1.req_f = 1'b0;
    step();
    checks++;
    if ({b1.ack_f, b1.busy} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_done ack_f/busy=%b/%b expected=0/0", b1.ack_f, b1.busy);
    end
  endtask

  task automatic test_store();
    b1.req_d   = 1'b1;
    b1.we_d    = 1'b1;
    b1.addr_d  = 16'h0040;
    b1.wdata_d = 64'h1234;
    step();
    checks++;
    if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== {1'b1, 1'b1, 16'h0040, 64'h1234}) begin
      failures++;
      $display("FAIL store_issue en/we/addr/wdata=%b/%b/%h/%h expected=1/1/0040/1234",
               b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
    end
    step();
    checks++;
    if ({b1.ack_d, b1.ack_f} !== 2'b10) begin
      failures++;
      $display("FAIL store_ack ack_d/ack_f=%b/%b expected=1/0", b1.ack_d, b1.ack_f);
    end
    checks++;
    if (b1.rdata !== 64'h00000000DEADBEEF) begin
      failures++;
      $display("FAIL store_rdata_kept got=%h expected=00000000deadbeef", b1.rdata);
    end
    b1.req_d = 1'b0;
    b1.we_d  = 1'b0;
    step();
    checks++;
    if ({b1.ack_d, b1.busy} !== 2'b00) begin
      failures++;
      $display("FAIL store_done ack_d/busy=%b/%b expected=0/0", b1.ack_d, b1.busy);
    end
    b1.req_d = 1'b1;
    step();
    step();
    step();
    checks++;
    if ({b1.ack_d, b1.rdata} !== {1'b1, 64'h1234}) begin
      failures++;
      $display("FAIL load_after_store ack_d/rdata=%b/%h expected=1/1234", b1.ack_d, b1.rdata);
    end
    b1.req_d = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    int t_d = 0;
    int t_f = 0;
    logic [63:0] rd_f = 64'd0;
    b1.addr_f = 16'h0010;
    b1.addr_d = 16'h0040;
    b1.we_d   = 1'b0;
    b1.req_f  = 1'b1;
    b1.req_d  = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (b1.ack_d && t_d == 0) begin
        t_d = cyc;
        b1.req_d = 1'b0;
      end
      if (b1.ack_f) begin
        t_f = cyc;
        rd_f = b1.rdata;
        b1.req_f = 1'b0;
        break;
      end
    end
    b1.req_f = 1'b0;
    b1.req_d = 1'b0;
    checks++;
    if (t_d !== 3) begin
      failures++;
      $display("FAIL simul_data_first ack_d_cycle=%0d expected=3", t_d);
    end
    checks++;
    if (t_f !== 7) begin
      failures++;
      $display("FAIL simul_fetch_after ack_f_cycle=%0d expected=7", t_f);
    end
    checks++;
    if (rd_f !== 64'h00000000DEADBEEF) begin
      failures++;
      $display("FAIL simul_fetch_rdata got=%h expected=00000000deadbeef", rd_f);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [9:0] seq = 10'd0;
    int n = 0;
    int overlap = 0;
    b1.addr_f = 16'h0010;
    b1.addr_d = 16'h0040;
    b1.we_d   = 1'b0;
    b1.req_f  = 1'b1;
    b1.req_d  = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step();
      if (b1.ack_d && b1.ack_f) overlap++;
      if (b1.ack_d || b1.ack_f) begin
        seq = {seq[8:0], b1.ack_d};
        n++;
      end
      if (n == 10) break;
    end
    b1.req_f = 1'b0;
    b1.req_d = 1'b0;
    checks++;
    if (seq !== 10'b1111011110 || n !== 10) begin
      failures++;
      $display("FAIL fairness_order got=%b (n=%0d) expected=1111011110 (D=1)", seq, n);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL fairness_ack_overlap got=%0d expected=0", overlap);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int active = 0;
    b1.addr_f = 16'h0010;
    b1.req_f  = 1'b1;
    step();
    #2 rst1 = 1'b1;
    #1;
    checks++;
    if (outs1() !== 149'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h expected=0", outs1());
    end
    b1.req_f = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (b1.ack_f || b1.ack_d || b1.busy || b1.mem_en) active++;
    end
    checks++;
    if (active !== 0) begin
      failures++;
      $display("FAIL reset_mid_quiet active_cycles=%0d expected=0", active);
    end
  endtask

  task automatic test_reset_wait();
    int acks = 0;
    int t = 0;
    logic [63:0] rd = 64'd0;
    b3.addr_f = 16'h0020;
    b3.req_f  = 1'b1;
    step();
    step();
    #2 rst3 = 1'b1;
    #1;
    checks++;
    if ({b3.busy, b3.ack_f, b3.mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_wait_outputs busy/ack_f/en=%b/%b/%b expected=0/0/0", b3.busy, b3.ack_f, b3.mem_en);
    end
    b3.req_f = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b3.ack_f) acks++;
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL reset_wait_no_ack got=%0d expected=0", acks);
    end
    b3.req_f = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (b3.ack_f) begin
        t = cyc;
        rd = b3.rdata;
        break;
      end
    end
    b3.req_f = 1'b0;
    checks++;
    if (t !== 5) begin
      failures++;
      $display("FAIL reset_wait_refetch_latency got=%0d expected=5", t);
    end
    checks++;
    if (rd !== 64'h00000000CAFEF00D) begin
      failures++;
      $display("FAIL reset_wait_refetch_rdata got=%h expected=00000000cafef00d", rd);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram1[i] = 64'd0;
      ram3[i] = 64'd0;
    end
    ram1[8'h10] = 64'h00000000DEADBEEF;
    ram3[8'h20] = 64'h00000000CAFEF00D;
    b1.req_f = 1'b0; b1.addr_f = 16'd0; b1.req_d = 1'b0; b1.we_d = 1'b0;
    b1.addr_d = 16'd0; b1.wdata_d = 64'd0;
    b3.req_f = 1'b0; b3.addr_f = 16'd0; b3.req_d = 1'b0; b3.we_d = 1'b0;
    b3.addr_d = 16'd0; b3.wdata_d = 64'd0;
    @(negedge clock);
    test_reset();
    rst1 = 1'b0;
    rst3 = 1'b0;
    test_idle();
    test_fetch();
    test_store();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
